// File: rtl/gl_pkg.sv
// Shared definitions for the GL command path: opcodes, word fields, fetch FSM states.
package gl_pkg;
  localparam logic [7:0] OP_NOP       = 8'hFF;
  localparam logic [7:0] OP_COLOR     = 8'h04;
  localparam logic [7:0] OP_TRANSLATE = 8'h18;
  localparam logic [7:0] OP_VIEWPORT  = 8'h19;

  localparam int OPC_LSB  = 24;
  localparam int TYPE_BIT = 23;
  localparam int IMM_W    = 23;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_OPND, S_ISSUE, S_HOLD, S_GAP, S_DONE
  } state_t;

  function automatic logic [2:0] op_operand_count(input logic [7:0] op);
    case (op)
      OP_COLOR:    return 3'd1;
      OP_VIEWPORT: return 3'd4;
      default:     return 3'd0;
    endcase
  endfunction

  function automatic logic op_is_legal(input logic [7:0] op);
    return (op >= 8'h01 && op <= 8'h04) || (op >= 8'h10 && op <= 8'h1A);
  endfunction
endpackage

// File: rtl/gl_fetch_opnd.sv
// Operand capture: writes the pipelined read stream into operand_0..3 in order.
module gl_fetch_opnd (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [2:0]  num,
  input  logic        cap,
  input  logic [31:0] data,
  output logic        last,
  output logic [31:0] operand_0,
  output logic [31:0] operand_1,
  output logic [31:0] operand_2,
  output logic [31:0] operand_3
);
  logic [3:0][31:0] opnd;
  logic [1:0]       idx;
  logic [2:0]       num_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      opnd  <= '0;
      idx   <= '0;
      num_q <= '0;
    end else if (load) begin
      idx   <= '0;
      num_q <= num;
    end else if (cap) begin
      opnd[idx] <= data;
      idx       <= idx + 2'd1;
    end
  end

  assign last      = ({1'b0, idx} + 3'd1) == num_q;
  assign operand_0 = opnd[0];
  assign operand_1 = opnd[1];
  assign operand_2 = opnd[2];
  assign operand_3 = opnd[3];
endmodule

// File: rtl/gl_fetch.sv
// Command fetch/issue unit feeding gl_decode. GL_FETCH_OPCODE_CHECK_EN enables
// skipping of unknown opcodes with a sticky illegal_op flag. The type bit is cmd_type.
module gl_fetch
  import gl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  cmd_count,
  output logic [ADDR_W-1:0] bram_addr_out,
  input  logic [31:0]       bram_read_in,
  output logic [7:0]        opcode,
  output logic [22:0]       imm,
  output logic              cmd_type,
  output logic [31:0]       operand_0,
  output logic [31:0]       operand_1,
  output logic [31:0]       operand_2,
  output logic [31:0]       operand_3,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  issued_count,
  output logic              illegal_op
);
  state_t              state, state_n;
  logic [ADDR_W-1:0]   ptr;
  logic [CNT_W-1:0]    remaining;
  logic [7:0]          cmd_op;
  logic [IMM_W-1:0]    cmd_imm;
  logic                cmd_typ;
  logic [2:0]          issue_left;
  logic                req, rd_vld, hold2, cap, last, legal;
  logic [7:0]          rd_op;
  logic [2:0]          rd_n;

  assign rd_op = bram_read_in[31:OPC_LSB];
  assign rd_n  = op_operand_count(rd_op);
  assign cap   = (state == S_OPND) && rd_vld;

`ifdef GL_FETCH_OPCODE_CHECK_EN
  logic illegal_q;
  assign legal = op_is_legal(rd_op);
  always_ff @(posedge clk) begin
    if (rst)                                illegal_q <= 1'b0;
    else if (state == S_IDLE && start)      illegal_q <= 1'b0;
    else if (state == S_DECODE && !legal)   illegal_q <= 1'b1;
  end
  assign illegal_op = illegal_q;
`else
  assign legal      = 1'b1;
  assign illegal_op = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // An empty list passes through GAP so done keeps the same GAP-to-done spacing.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (start) state_n = (cmd_count == '0) ? S_GAP : S_FETCH;
      S_FETCH:  state_n = S_DECODE;
      S_DECODE: state_n = !legal ? S_GAP : (rd_n != 3'd0) ? S_OPND : S_ISSUE;
      S_OPND:   if (cap && last) state_n = S_ISSUE;
      S_ISSUE:  state_n = S_HOLD;
      S_HOLD:   if (hold2 && !stall) state_n = S_GAP;
      S_GAP:    state_n = (remaining == '0) ? S_DONE : S_FETCH;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_comb begin
    opcode   = OP_NOP;
    imm      = '0;
    cmd_type = 1'b0;
    if (state == S_ISSUE || state == S_HOLD) begin
      opcode   = cmd_op;
      imm      = cmd_imm;
      cmd_type = cmd_typ;
    end
    busy = !(state == S_IDLE || state == S_DONE);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr           <= '0;
      remaining     <= '0;
      cmd_op        <= OP_NOP;
      cmd_imm       <= '0;
      cmd_typ       <= 1'b0;
      issue_left    <= '0;
      req           <= 1'b0;
      rd_vld        <= 1'b0;
      hold2         <= 1'b0;
      bram_addr_out <= '0;
      issued_count  <= '0;
    end else begin
      rd_vld <= req;
      case (state)
        S_IDLE: if (start) begin
          remaining    <= cmd_count;
          issued_count <= '0;
          if (cmd_count != '0) begin
            ptr           <= base_addr;
            bram_addr_out <= base_addr;
          end
        end
        S_FETCH: ptr <= ptr + 1'b1;
        S_DECODE: begin
          cmd_op  <= rd_op;
          cmd_typ <= bram_read_in[TYPE_BIT];
          cmd_imm <= bram_read_in[IMM_W-1:0];
          if (!legal) begin
            remaining <= remaining - 1'b1;
          end else if (rd_n != 3'd0) begin
            bram_addr_out <= ptr;
            ptr           <= ptr + 1'b1;
            issue_left    <= rd_n - 3'd1;
            req           <= 1'b1;
          end
        end
        // Addresses run one cycle ahead of the captured data.
        S_OPND: begin
          if (issue_left != 3'd0) begin
            bram_addr_out <= ptr;
            ptr           <= ptr + 1'b1;
            issue_left    <= issue_left - 3'd1;
          end else begin
            req <= 1'b0;
          end
        end
        S_ISSUE: begin
          issued_count <= issued_count + 1'b1;
          hold2        <= 1'b0;
        end
        S_HOLD: begin
          hold2 <= 1'b1;
          if (hold2 && !stall) remaining <= remaining - 1'b1;
        end
        S_GAP: if (remaining != '0) bram_addr_out <= ptr;
        default: ;
      endcase
    end
  end

  gl_fetch_opnd u_opnd (
    .clk       (clk),
    .rst       (rst),
    .load      (state == S_DECODE),
    .num       (rd_n),
    .cap       (cap),
    .data      (bram_read_in),
    .last      (last),
    .operand_0 (operand_0),
    .operand_1 (operand_1),
    .operand_2 (operand_2),
    .operand_3 (operand_3)
  );
endmodule
